// File: rtl/var_shift_packer.sv
// var_shift_packer: packs variable-length, MSB-aligned codewords into a
// continuous MSB-first stream of DATA_W-bit words with in-band termination.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no stream open, accumulator empty
// FILL  | stream open, last codeword not yet seen
// DRAIN | last codeword accepted, emitting remaining words
module var_shift_packer #(
  parameter int DATA_W   = 8,
  parameter int MAX_IN_W = 2 * DATA_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [MAX_IN_W-1:0]           data_i,
  input  logic [$clog2(MAX_IN_W+1)-1:0] len_i,
  input  logic                          last_i,
  input  logic                          vld_i,
  output logic                          rdy_o,
  output logic [DATA_W-1:0]             data_o,
  output logic [$clog2(DATA_W+1)-1:0]   vld_bits_o,
  output logic                          last_o,
  output logic                          vld_o,
  input  logic                          rdy_i,
  output logic                          idle_o
);

  localparam int ACC_W = DATA_W - 1 + MAX_IN_W;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int LEN_W = $clog2(MAX_IN_W + 1);
  localparam int VB_W  = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] DW_CNT  = CNT_W'(DATA_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_IN_W);
  localparam logic [VB_W-1:0]  DW_VB   = VB_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pop, push;
  logic [CNT_W-1:0]   cnt_pop;
  logic [ACC_W-1:0]   acc_pop;
  logic [MAX_IN_W-1:0] masked;
  logic [ACC_W-1:0]   aligned;

  // Output side: decoded purely from registered state so vld_o never
  // depends on the input handshake or rdy_i.
  always_comb begin
    data_o     = acc_q[ACC_W-1 -: DATA_W];
    vld_o      = (state_q == DRAIN) || (cnt_q >= DW_CNT);
    last_o     = (state_q == DRAIN) && (cnt_q <= DW_CNT);
    idle_o     = (state_q == IDLE);
    vld_bits_o = '0;
    if (vld_o) vld_bits_o = last_o ? cnt_q[VB_W-1:0] : DW_VB;
  end

  // Datapath: pop is applied first, then the masked codeword is ORed in
  // right after the bits that survive the pop.
  always_comb begin
    pop     = vld_o && rdy_i;
    cnt_pop = cnt_q;
    acc_pop = acc_q;
    if (pop) begin
      // Floor at zero: the final DRAIN word may hold fewer than DATA_W bits.
      cnt_pop = (cnt_q > DW_CNT) ? (cnt_q - DW_CNT) : '0;
      acc_pop = acc_q << DATA_W;
    end
    rdy_o   = (state_q != DRAIN) && (cnt_pop < DW_CNT);
    push    = vld_i && rdy_o;
    masked  = data_i & ~({MAX_IN_W{1'b1}} >> len_i);
    aligned = {masked, {(ACC_W-MAX_IN_W){1'b0}}} >> cnt_pop;
    acc_d   = acc_pop;
    cnt_d   = cnt_pop;
    if (push) begin
      acc_d = acc_pop | aligned;
      cnt_d = cnt_pop + CNT_W'(len_i);
    end
  end

  // Next-state logic; a zero-length FILL stays open until last arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = last_i ? DRAIN : FILL;
      FILL:    if (push && last_i) state_d = DRAIN;
      DRAIN:   if (pop && last_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and accumulator registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Codeword length beyond MAX_IN_W is illegal.
  len_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
                              vld_i |-> (len_i <= LEN_MAX));

endmodule

// File: tb/tb_var_shift_packer.sv
// Directed bench for var_shift_packer (DATA_W=8, MAX_IN_W=16).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_var_shift_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] data_i;
  logic [4:0]  len_i;
  logic        last_i;
  logic        vld_i;
  logic        rdy_o;
  logic [7:0]  data_o;
  logic [3:0]  vld_bits_o;
  logic        last_o;
  logic        vld_o;
  logic        rdy_i;
  logic        idle_o;

  int n_tests = 0;
  int n_fail  = 0;

  var_shift_packer #(.DATA_W(8), .MAX_IN_W(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .len_i      (len_i),
    .last_i     (last_i),
    .vld_i      (vld_i),
    .rdy_o      (rdy_o),
    .data_o     (data_o),
    .vld_bits_o (vld_bits_o),
    .last_o     (last_o),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .idle_o     (idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one codeword and hold it until accepted (bounded wait).
  task automatic drive(input logic [15:0] d, input logic [4:0] l, input logic lst);
    int waited;
    data_i = d;
    len_i  = l;
    last_i = lst;
    vld_i  = 1'b1;
    waited = 0;
    @(negedge clk_i);
    while (!rdy_o && waited < 20) begin
      waited++;
      @(negedge clk_i);
    end
    if (!rdy_o) check_val("push_timeout", 32'(rdy_o), 32'd1);
    @(posedge clk_i);
    #1;
    vld_i  = 1'b0;
    last_i = 1'b0;
    data_i = '0;
    len_i  = '0;
  endtask

  initial begin
    rst_ni = 1'b0;
    data_i = '0;
    len_i  = '0;
    last_i = 1'b0;
    vld_i  = 1'b0;
    rdy_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // reset state
    @(negedge clk_i);
    check_val("rst_vld",   32'(vld_o),      32'd0);
    check_val("rst_last",  32'(last_o),     32'd0);
    check_val("rst_data",  32'(data_o),     32'h00);
    check_val("rst_bits",  32'(vld_bits_o), 32'd0);
    check_val("rst_idle",  32'(idle_o),     32'd1);
    check_val("rst_rdy",   32'(rdy_o),      32'd1);

    // 1: full-width word
    @(posedge clk_i); #1;
    drive(16'hA500, 5'd8, 1'b0);
    @(negedge clk_i);
    check_val("t1_vld",  32'(vld_o),      32'd1);
    check_val("t1_data", 32'(data_o),     32'hA5);
    check_val("t1_bits", 32'(vld_bits_o), 32'd8);
    check_val("t1_last", 32'(last_o),     32'd0);
    @(negedge clk_i);
    check_val("t1_idle_after", 32'(idle_o), 32'd0);
    check_val("t1_vld_after",  32'(vld_o),  32'd0);

    // 2: 3 + 5 bits merge into one word
    @(posedge clk_i); #1;
    drive(16'hA000, 5'd3, 1'b0);
    drive(16'hC800, 5'd5, 1'b0);
    @(negedge clk_i);
    check_val("t2_data", 32'(data_o),     32'hB9);
    check_val("t2_bits", 32'(vld_bits_o), 32'd8);
    @(negedge clk_i);
    check_val("t2_empty", 32'(vld_o), 32'd0);

    // 3: masking and zero-length last
    @(posedge clk_i); #1;
    drive(16'hFF00, 5'd3, 1'b0);
    drive(16'h0000, 5'd0, 1'b1);
    @(negedge clk_i);
    check_val("t3_data", 32'(data_o),     32'hE0);
    check_val("t3_bits", 32'(vld_bits_o), 32'd3);
    check_val("t3_last", 32'(last_o),     32'd1);
    check_val("t3_rdy",  32'(rdy_o),      32'd0);
    @(negedge clk_i);
    check_val("t3_idle", 32'(idle_o), 32'd1);

    // 4: 16-bit codeword with last splits into two words
    @(posedge clk_i); #1;
    drive(16'h1234, 5'd16, 1'b1);
    @(negedge clk_i);
    check_val("t4_w0_data", 32'(data_o),     32'h12);
    check_val("t4_w0_last", 32'(last_o),     32'd0);
    check_val("t4_w0_bits", 32'(vld_bits_o), 32'd8);
    check_val("t4_w0_rdy",  32'(rdy_o),      32'd0);
    @(negedge clk_i);
    check_val("t4_w1_data", 32'(data_o),     32'h34);
    check_val("t4_w1_last", 32'(last_o),     32'd1);
    check_val("t4_w1_bits", 32'(vld_bits_o), 32'd8);
    check_val("t4_w1_rdy",  32'(rdy_o),      32'd0);
    @(negedge clk_i);
    check_val("t4_idle", 32'(idle_o), 32'd1);
    check_val("t4_vld",  32'(vld_o),  32'd0);

    // 5: backpressure holds the word and blocks input
    @(posedge clk_i); #1;
    rdy_i = 1'b0;
    drive(16'hFF00, 5'd8, 1'b0);
    data_i = 16'hF800;
    len_i  = 5'd5;
    last_i = 1'b1;
    vld_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_val("t5_hold_data", 32'(data_o), 32'hFF);
      check_val("t5_hold_rdy",  32'(rdy_o),  32'd0);
      @(posedge clk_i); #1;
    end
    rdy_i = 1'b1;
    @(negedge clk_i);
    check_val("t5_rel_data", 32'(data_o), 32'hFF);
    check_val("t5_rel_rdy",  32'(rdy_o),  32'd1);
    @(posedge clk_i); #1;
    vld_i  = 1'b0;
    last_i = 1'b0;
    @(negedge clk_i);
    check_val("t5_tail_data", 32'(data_o),     32'hF8);
    check_val("t5_tail_bits", 32'(vld_bits_o), 32'd5);
    check_val("t5_tail_last", 32'(last_o),     32'd1);
    @(negedge clk_i);
    check_val("t5_idle", 32'(idle_o), 32'd1);

    // 6a: zero-length stream
    @(posedge clk_i); #1;
    drive(16'h0000, 5'd0, 1'b1);
    @(negedge clk_i);
    check_val("t6_vld",  32'(vld_o),      32'd1);
    check_val("t6_data", 32'(data_o),     32'h00);
    check_val("t6_bits", 32'(vld_bits_o), 32'd0);
    check_val("t6_last", 32'(last_o),     32'd1);
    @(negedge clk_i);
    check_val("t6_idle", 32'(idle_o), 32'd1);
    check_val("t6_done", 32'(vld_o),  32'd0);

    // 6b: reset during DRAIN discards the stream
    @(posedge clk_i); #1;
    rdy_i = 1'b0;
    drive(16'h1234, 5'd16, 1'b1);
    @(negedge clk_i);
    check_val("t6r_pre_vld", 32'(vld_o), 32'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    rdy_i  = 1'b1;
    @(negedge clk_i);
    check_val("t6r_vld",  32'(vld_o),  32'd0);
    check_val("t6r_idle", 32'(idle_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_val("t6r_quiet", 32'(vld_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/var_shift_packer.md
# var_shift_packer

Parametrised bit-packer for the EBPC encoder output path. It accepts variable-length, MSB-aligned codewords of up to MAX_IN_W bits and packs them into a continuous MSB-first stream of DATA_W-bit words. An in-band `last_i` terminates a stream: the block zero-pads the final word, flags it with `last_o` and reports how many of its bits are valid. Compared with a fixed 2·DATA_W packer, it adds independent input/output widths, input masking, in-band termination and full-throughput push/pop.

## Interface
- DATA_W, default 8: output word width (≥ 2).
- MAX_IN_W, default 2*DATA_W: maximum codeword length (1 … 4*DATA_W).
- ACC_W (derived, not overridable): DATA_W-1+MAX_IN_W, accumulator width.
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- data_i  in  MAX_IN_W  codeword, MSB-aligned; bits below the top len_i bits are ignored.
- len_i  in  $clog2(MAX_IN_W+1)  codeword length, 0 … MAX_IN_W.
- last_i  in  1  codeword is the final one of the stream.
- vld_i  in  1  input valid.
- rdy_o  out  1  input ready.
- data_o  out  DATA_W  packed output word, first bit in MSB.
- vld_bits_o  out  $clog2(DATA_W+1)  valid bits in data_o, counted from the MSB.
- last_o  out  1  data_o is the final word of the stream.
- vld_o  out  1  output valid.
- rdy_i  in  1  output ready.
- idle_o  out  1  no buffered bits and no stream in progress.

## Operation
- Accumulator acc_q[ACC_W-1:0] holds cnt_q valid bits in its top positions. All bits below them are zero (invariant).
- data_o = acc_q[ACC_W-1 -: DATA_W].
- Masking: data_i is ANDed with a mask of len_i ones starting at the MSB. len_i = 0 contributes nothing.
- Handshakes: an input is accepted when vld_i && rdy_o; a word is popped when vld_o && rdy_i.
- Pop: acc shifts left by DATA_W with zero fill. cnt drops by DATA_W, floored at 0 in DRAIN.
- Push: the masked data is ORed in at offset (cnt after pop), i.e. `acc |= masked << (ACC_W - MAX_IN_W) >> cnt_after_pop`. cnt_after_pop increases by len_i.
- States:
  - IDLE: cnt_q = 0.
  - FILL: stream in progress, no last seen.
  - DRAIN: last accepted.
- Transitions:
  - IDLE→FILL on an accepted push without last_i.
  - IDLE/FILL→DRAIN on an accepted push with last_i.
  - DRAIN→IDLE on the pop with last_o.
  - FILL with cnt = 0 stays in FILL (stream still open).
- rdy_o = (state ≠ DRAIN) && (cnt_after_pop < DATA_W), where cnt_after_pop = cnt_q − (vld_o && rdy_i ? DATA_W : 0). rdy_o may depend combinationally on rdy_i. vld_o never depends on vld_i or rdy_i.
- vld_o in IDLE/FILL: cnt_q ≥ DATA_W.
- vld_o in DRAIN: always 1 (covers cnt_q > 0, plus the zero-length case below).
- last_o = DRAIN && cnt_q ≤ DATA_W.
- vld_bits_o:
  - DATA_W on every non-last word.
  - cnt_q on the last word; equals DATA_W when the stream length is a multiple of DATA_W.
  - 0 whenever vld_o = 0.
- Zero-length stream (last_i, len_i = 0, cnt_q = 0): emits one all-zero word with last_o = 1 and vld_bits_o = 0.
- idle_o = (state = IDLE).
- Arithmetic: cnt is $clog2(ACC_W+1) bits wide and never exceeds ACC_W. A len_i > MAX_IN_W is illegal; assertion only.

## Timing
- Reset (synchronous, rst_ni low at a clk_i edge): acc_q = 0, cnt_q = 0, state IDLE.
- Outputs after reset: vld_o = 0, last_o = 0, data_o = 0, vld_bits_o = 0, idle_o = 1, rdy_o = 1.
- Reset mid-stream (FILL or DRAIN) discards all buffered bits. No word is emitted after that edge.
- Latency: a push that brings cnt ≥ DATA_W raises vld_o in the next cycle.
- Throughput: one push and one pop per cycle sustained when MAX_IN_W ≤ DATA_W and rdy_i = 1.
- Simultaneous push and pop in the same cycle: the pop is applied first, then the push.
- DRAIN holds rdy_o = 0. A new stream can be accepted the cycle after the last_o pop; the first input of the new stream is never merged into the old last word.
- With rdy_i = 0: data_o, vld_bits_o and last_o stay stable while vld_o = 1. rdy_o drops once cnt_q ≥ DATA_W.

## Test plan
1. DATA_W=8, MAX_IN_W=8: push 0xA5 (len 8) → next cycle vld_o = 1, data_o = 0xA5, vld_bits_o = 8; after the pop, idle_o = 0 and the state is FILL.
2. Push 0xA0 (len 3), then 0xC8 (len 5) → one word 0xB9, vld_bits_o = 8; cnt returns to 0.
3. Push 0xFF (len 3), then 0x00 (len 0, last_i) → data_o = 0xE0, vld_bits_o = 3, last_o = 1; masked bits absent; idle_o = 1 the following cycle.
4. DATA_W=8, MAX_IN_W=16: push 0x1234 (len 16, last_i) with rdy_i = 1 → words 0x12 then 0x34 on consecutive cycles. Only the second has last_o = 1, vld_bits_o = 8. rdy_o = 0 throughout DRAIN.
5. Backpressure: push 0xFF (len 8), then 0xF8 (len 5); hold rdy_i = 0 for 5 cycles → data_o stays 0xFF and rdy_o = 0. Release → 0xFF, then (after last) 0xF8 with vld_bits_o = 5.
6. Zero-length stream: push last_i with len_i = 0 from IDLE → one word 0x00, vld_bits_o = 0, last_o = 1. Separately, assert rst_ni low mid-DRAIN → the next cycle shows vld_o = 0, idle_o = 1 and no further words.
